// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder and its bus interface.
package mem_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 20;
   localparam int BUS_W     = 20;
   localparam int ADDR_HI_W = BUS_W - ADDR_W;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } mem_state_t;

endpackage

// File: rtl/memory_responder_if.sv
// Core bus plus boot-loader stream port between the processor side and the memory responder.
interface memory_responder_if;
   import mem_pkg::*;

   logic [BUS_W-1:0]  Daddress;
   logic [BUS_W-1:0]  Dout;
   logic              W;
   logic [DATA_W-1:0] DataIn;
   logic              LoadValid;
   logic [DATA_W-1:0] LoadData;
   logic              LoadLast;
   logic              LoadReady;
   logic              CpuHold;
   logic              OutOfRange;

   modport master (
      output Daddress, Dout, W, LoadValid, LoadData, LoadLast,
      input  DataIn, LoadReady, CpuHold, OutOfRange
   );

   modport slave (
      input  Daddress, Dout, W, LoadValid, LoadData, LoadLast,
      output DataIn, LoadReady, CpuHold, OutOfRange
   );

endinterface

// File: rtl/memory_responder_sync_ram_wf.sv
// Single-port synchronous RAM; a write also returns the written word on the registered output.
module sync_ram_wf #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 20
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Commit the write and forward it to the output so a same-address read sees the new word.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: boot loader fills the RAM while holding the core, then serves core reads/writes.
module memory_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W
) (
   input logic          Clock,
   input logic          Reset,
   memory_responder_if.slave bus
);

   mem_state_t        state;
   mem_state_t        state_next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_next;
   logic              beat;
   logic              in_range;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              zero_data;
   logic              oor_flag;

   assign in_range = (bus.Daddress[BUS_W-1:ADDR_W] == '0);

   // State, load pointer, output-zeroing flag and sticky range error; Reset wins over everything.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= LOAD;
         ptr       <= '0;
         zero_data <= 1'b1;
         oor_flag  <= 1'b0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         zero_data <= (state == LOAD) || !in_range;
         if ((state == RUN) && !in_range) begin
            oor_flag <= 1'b1;
         end
      end
   end

   // Next state and RAM port steering: loader owns the RAM in LOAD, the core owns it in RUN.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      beat       = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = bus.Daddress[ADDR_W-1:0];
      ram_wdata  = bus.Dout;
      case (state)
         LOAD: begin
            beat      = bus.LoadValid;
            ram_addr  = ptr;
            ram_wdata = bus.LoadData;
            ram_we    = beat && !Reset;
            if (beat) begin
               ptr_next = ptr + 1'b1;
               if (bus.LoadLast || (&ptr)) begin
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            ram_we = bus.W && in_range && !Reset;
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   sync_ram_wf #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ram (
      .clock(Clock),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );

   assign bus.LoadReady  = (state == LOAD);
   assign bus.CpuHold    = (state == LOAD);
   assign bus.OutOfRange = oor_flag;
   assign bus.DataIn     = zero_data ? '0 : ram_rdata;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: boot load, core reads/writes, range errors and resets.
module tb_memory_responder;

   logic Clock;
   logic Reset;
   int   compared;
   int   mismatched;

   memory_responder_if bus ();

   memory_responder dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus.slave)
   );

   // Free-running clock, 10 time units per period.
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic applyStimulus(input logic rst, input logic lv, input logic [19:0] ld,
                                input logic ll, input logic [19:0] addr,
                                input logic [19:0] dout, input logic w);
      Reset         = rst;
      bus.LoadValid = lv;
      bus.LoadData  = ld;
      bus.LoadLast  = ll;
      bus.Daddress  = addr;
      bus.Dout      = dout;
      bus.W         = w;
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic checkOutput(input string tag, input logic [19:0] observed,
                              input logic [19:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%05h, expected 0x%05h", tag, observed, expected);
      end
   endtask

   // Linear sequence of directed steps, each followed by its hand-computed checks.
   initial begin
      compared   = 0;
      mismatched = 0;
      Reset         = 1'b1;
      bus.LoadValid = 1'b0;
      bus.LoadData  = '0;
      bus.LoadLast  = 1'b0;
      bus.Daddress  = '0;
      bus.Dout      = '0;
      bus.W         = 1'b0;
      @(negedge Clock);

      applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("reset_datain",     bus.DataIn,            20'h0);
      checkOutput("reset_loadready",  20'(bus.LoadReady),    20'h1);
      checkOutput("reset_cpuhold",    20'(bus.CpuHold),      20'h1);
      checkOutput("reset_outofrange", 20'(bus.OutOfRange),   20'h0);

      applyStimulus(1'b0, 1'b1, 20'hD0010, 1'b0, 20'h0, 20'h0, 1'b1);
      checkOutput("load3_hold_beat1", 20'(bus.CpuHold), 20'h1);
      checkOutput("load3_data_zero",  bus.DataIn,       20'h0);
      applyStimulus(1'b0, 1'b1, 20'h00120, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("load3_hold_beat2", 20'(bus.CpuHold), 20'h1);
      applyStimulus(1'b0, 1'b1, 20'hC3100, 1'b1, 20'h0, 20'h0, 1'b0);
      checkOutput("load3_hold_fell",  20'(bus.CpuHold),   20'h0);
      checkOutput("load3_ready_fell", 20'(bus.LoadReady), 20'h0);
      checkOutput("load3_first_run",  bus.DataIn,         20'h0);

      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("read_addr0", bus.DataIn, 20'hD0010);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h1, 20'h0, 1'b0);
      checkOutput("read_addr1", bus.DataIn, 20'h00120);
      applyStimulus(1'b0, 1'b1, 20'hFFFFF, 1'b1, 20'h2, 20'h0, 1'b0);
      checkOutput("read_addr2",        bus.DataIn,       20'hC3100);
      checkOutput("run_ignores_load",  20'(bus.CpuHold), 20'h0);

      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h5, 20'h0ABCD, 1'b1);
      checkOutput("write_first_same_edge", bus.DataIn, 20'h0ABCD);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h1, 20'h0, 1'b0);
      checkOutput("write_other_addr", bus.DataIn, 20'h00120);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h5, 20'h0, 1'b0);
      checkOutput("write_readback5", bus.DataIn, 20'h0ABCD);

      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'd10, 20'h05A5A, 1'b1);
      checkOutput("store10_forward", bus.DataIn, 20'h05A5A);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h2, 20'h11111, 1'b0);
      checkOutput("store10_between", bus.DataIn, 20'hC3100);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'd10, 20'h0, 1'b0);
      checkOutput("load10_r2", bus.DataIn, 20'h05A5A);

      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h00100, 20'h01234, 1'b1);
      checkOutput("oor_datain", bus.DataIn,          20'h0);
      checkOutput("oor_flag",   20'(bus.OutOfRange), 20'h1);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("oor_mem0_kept", bus.DataIn,          20'hD0010);
      checkOutput("oor_sticky",    20'(bus.OutOfRange), 20'h1);

      applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("rstrun_cpuhold",    20'(bus.CpuHold),    20'h1);
      checkOutput("rstrun_loadready",  20'(bus.LoadReady),  20'h1);
      checkOutput("rstrun_outofrange", 20'(bus.OutOfRange), 20'h0);
      checkOutput("rstrun_datain",     bus.DataIn,          20'h0);

      applyStimulus(1'b0, 1'b1, 20'hAAAA1, 1'b0, 20'h0, 20'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 20'hAAAA2, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("rstload_hold_mid", 20'(bus.CpuHold), 20'h1);
      applyStimulus(1'b1, 1'b1, 20'hBAD00, 1'b1, 20'h0, 20'h0, 1'b0);
      checkOutput("rstload_cpuhold", 20'(bus.CpuHold),   20'h1);
      checkOutput("rstload_ready",   20'(bus.LoadReady), 20'h1);
      applyStimulus(1'b0, 1'b1, 20'h11111, 1'b0, 20'h0, 20'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 20'h22222, 1'b0, 20'h0, 20'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 20'h33333, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("reload_hold_beat3", 20'(bus.CpuHold), 20'h1);
      applyStimulus(1'b0, 1'b1, 20'h44444, 1'b1, 20'h0, 20'h0, 1'b0);
      checkOutput("reload_hold_fell", 20'(bus.CpuHold), 20'h0);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("reload_addr0", bus.DataIn, 20'h11111);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h1, 20'h0, 1'b0);
      checkOutput("reload_addr1", bus.DataIn, 20'h22222);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h2, 20'h0, 1'b0);
      checkOutput("reload_addr2", bus.DataIn, 20'h33333);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h3, 20'h0, 1'b0);
      checkOutput("reload_addr3", bus.DataIn, 20'h44444);

      applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b0, 1'b1, 20'h80000 | 20'(i), 1'b0, 20'h0, 20'h0, 1'b0);
         if (i == 254) begin
            checkOutput("full_hold_beat255", 20'(bus.CpuHold), 20'h1);
         end
      end
      checkOutput("full_hold_fell",  20'(bus.CpuHold),   20'h0);
      checkOutput("full_ready_fell", 20'(bus.LoadReady), 20'h0);
      applyStimulus(1'b0, 1'b1, 20'h7FFFF, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("full_addr0", bus.DataIn, 20'h80000);
      applyStimulus(1'b0, 1'b1, 20'h7FFFF, 1'b0, 20'hFF, 20'h0, 1'b0);
      checkOutput("full_addr255", bus.DataIn, 20'h800FF);
      applyStimulus(1'b0, 1'b1, 20'h7FFFF, 1'b0, 20'h3, 20'h0, 1'b0);
      checkOutput("full_addr3", bus.DataIn, 20'h80003);
      applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, 1'b0);
      checkOutput("full_addr0_after_extra_valid", bus.DataIn, 20'h80000);
      checkOutput("full_still_run", 20'(bus.CpuHold), 20'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
